mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  RV32I pipeline MEM stage; sits directly downstream of the execute stage.
//  Holds the EX/MEM pipeline register and the data-memory access FSM.
//  Also holds store byte-enable/data alignment, load extraction/extension and the MEM/WB register.
//  Stalls upstream while a data-cache access is outstanding.
// PARAMETERS
//  ADDR_W   32  data address width
//  DATA_W   32  data word width (fixed 32; other values unsupported)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous active-low reset (0 = reset)
//  ex_valid       in   1   EX result valid
//  ex_alu_out     in   32  ALU result; effective address for loads/stores
//  ex_rs2_out     in   32  store data
//  ex_ctrl        in   ctl rv32i_control_word (uses mem_read, mem_write, funct3)
//  ex_rd          in   5   destination register
//  ex_u_imm       in   32  U-immediate, passed to WB
//  ex_pc          in   32  instruction PC, passed to WB
//  mem_stall      out  1   1 = EX and earlier must hold; combinational
//  dmem_read      out  1   cache read request
//  dmem_write     out  1   cache write request
//  dmem_addr      out  32  word address {m_addr[31:2],2'b00}
//  dmem_wdata     out  32  store data, lane-shifted
//  dmem_mbe       out  4   byte enables (meaningful on write only)
//  dmem_rdata     in   32  cache read data, valid with dmem_resp
//  dmem_resp      in   1   one-cycle access-complete pulse
//  wb_valid       out  1   MEM/WB valid
//  wb_ctrl        out  ctl control word to WB
//  wb_rd          out  5   destination register
//  wb_alu_out     out  32  ALU result
//  wb_mem_rdata   out  32  extended load data (0 for non-loads)
//  wb_u_imm       out  32  U-immediate
//  wb_pc          out  32  instruction PC
//  wb_misalign    out  1   misaligned-access flag (MEM_MISALIGN_TRAP_EN only)
// BEHAVIOUR
//  Reset: all registers 0; FSM = IDLE; wb_valid = 0; all dmem_* and mem_stall = 0.
//  - memop = m_valid & (mem_read | mem_write); a = m_addr[1:0].
//  EX/MEM register:
//  - Captures ex_* and m_valid <= ex_valid on each edge with mem_stall = 0.
//  - Holds while mem_stall = 1.
//  FSM states: IDLE, WAIT, RECOV.
//  - IDLE: request = memop. If dmem_resp, complete and go to RECOV; else if memop, go to WAIT.
//  - WAIT: request held. On dmem_resp, complete and go to RECOV.
//  - RECOV: request forced 0 for one cycle (cache protocol); go to IDLE. New instruction may be latched.
//  Request and stall signals:
//  - dmem_read = request & mem_read; dmem_write = request & mem_write; never both.
//  - mem_stall = memop & ~dmem_resp in IDLE/WAIT.
//  - mem_stall = memop in RECOV, so a back-to-back memop waits a cycle.
//  Completion and MEM/WB register:
//  - Completion is the cycle with mem_stall = 0.
//  - MEM/WB captures on that edge: wb_valid <= m_valid; loads use dmem_rdata from the same cycle.
//  - When mem_stall = 1, the MEM/WB register loads a bubble (wb_valid <= 0).
//  - Non-memop instructions complete in 1 cycle (latency: EX/MEM edge to MEM/WB edge = 1).
//  Stores:
//  - sb: mbe = 4'b0001<<a.
//  - sh: mbe = 4'b0011<<a (4-bit truncated).
//  - sw: mbe = 4'hF.
//  - dmem_wdata = rs2 << (8*a).
//  Loads:
//  - lb/lbu select byte a; lh/lhu select half a[1]; lw selects the whole word.
//  - lb/lh sign-extend; lbu/lhu zero-extend.
//  Reset mid-access: FSM -> IDLE, request dropped immediately (async); in-flight response ignored.
//  - dmem_resp while ~memop is ignored.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//  - Misaligned access = lh/lhu/sh with a[0]=1, or lw/sw with a!=0.
//  - Misaligned access issues no request and completes in 1 cycle.
//  - wb_misalign = 1, wb_mem_rdata = 0, wb_valid = m_valid.
//  MEM_MISALIGN_TRAP_EN undefined:
//  - No check; behaviour follows the truncation rules above.
//  - wb_misalign is tied to 0.
// STRUCTURE
//  rv32i_types (shared package) gains:
//  - mem_state_t enum {IDLE, WAIT, RECOV}.
//  - Load/store funct3 enums (lb, lh, lw, lbu, lhu; sb, sh, sw).
//  Sub-module mem_align: combinational.
//  - Inputs: funct3, a, rs2, rdata.
//  - Outputs: mbe, wdata, ext_rdata, misaligned.
//  FSM and both pipeline registers live in mem_stage.
// TESTING
//  1. sw @0x104, rs2=0xDEADBEEF, resp after 2 cycles
//     -> dmem_addr=0x104, mbe=F, wdata=0xDEADBEEF.
//     -> mem_stall=1 for 2 cycles, then wb_valid=1.
//  2. sb @0x1003, rs2=0x000000AB -> mbe=4'b1000, wdata=0xAB000000.
//  3. lb @0x2001, rdata=0x12348056 -> wb_mem_rdata=0xFFFFFF80.
//     lbu at the same address -> wb_mem_rdata=0x00000080.
//  4. lhu @0x2002, rdata=0xF00D1234 -> wb_mem_rdata=0x0000F00D.
//  5. Back-to-back lw then sw, resp in 1 cycle each
//     -> one RECOV cycle with dmem_read = dmem_write = 0 between the requests.
//     -> both retire in order.
//  6. rst=0 during WAIT -> dmem_read=0 the same cycle; wb_valid=0; FSM=IDLE.
//  7. MEM_MISALIGN_TRAP_EN defined, lw @0x3002 -> no request; wb_misalign=1 next edge.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared RV32I types used by the MEM stage: control word, load/store funct3 codes
// and the data-memory access FSM state.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RECOV = 2'd2
  } mem_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } rv32i_control_word;

endpackage

// File: rtl/mem_stage_if.sv
// Data-cache bus between the MEM stage (master) and the data cache (slave).
interface mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   mbe;
  logic [DATA_W-1:0]     rdata;
  logic                  resp;

  modport master (output read, write, addr, wdata, mbe, input rdata, resp);
  modport slave  (input read, write, addr, wdata, mbe, output rdata, resp);
endinterface

// File: rtl/mem_stage_align.sv
// Combinational store lane alignment / byte enables, load extraction / extension,
// and misalignment detection for the MEM stage (DATA_W fixed at 32).
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        a,
  input  logic [DATA_W-1:0] rs2,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        mbe,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              misaligned
);

  function automatic logic signed [DATA_W-1:0] sext8(input logic signed [7:0] b);
    return DATA_W'(b);
  endfunction

  function automatic logic signed [DATA_W-1:0] sext16(input logic signed [15:0] h);
    return DATA_W'(h);
  endfunction

  logic [4:0]  shamt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shamt    = {a, 3'b000};
  assign byte_sel = 8'(rdata >> shamt);
  assign half_sel = a[1] ? rdata[31:16] : rdata[15:0];
  assign wdata    = rs2 << shamt;

  // halfword codes share funct3[1:0]=01 and word codes 10 across loads and stores
  assign misaligned = ((funct3[1:0] == 2'b01) & a[0]) |
                      ((funct3[1:0] == 2'b10) & (a != 2'b00));

  always_comb begin
    mbe = 4'hF;
    case (funct3)
      SB:      mbe = 4'b0001 << a;
      SH:      mbe = 4'b0011 << a;
      default: mbe = 4'hF;
    endcase
  end

  always_comb begin
    ext_rdata = rdata;
    case (funct3)
      LB:      ext_rdata = sext8(byte_sel);
      LH:      ext_rdata = sext16(half_sel);
      LBU:     ext_rdata = {24'b0, byte_sel};
      LHU:     ext_rdata = {16'b0, half_sel};
      default: ext_rdata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: EX/MEM register, data-cache access FSM, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned accesses into request-free trapping completions.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_rs2_out,
  input  rv32i_control_word ex_ctrl,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_u_imm,
  input  logic [DATA_W-1:0] ex_pc,
  output logic              mem_stall,
  mem_stage_if.master       dmem,
  output logic              wb_valid,
  output rv32i_control_word wb_ctrl,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_alu_out,
  output logic [DATA_W-1:0] wb_mem_rdata,
  output logic [DATA_W-1:0] wb_u_imm,
  output logic [DATA_W-1:0] wb_pc,
  output logic              wb_misalign
);

  logic              vld_p1;
  logic [DATA_W-1:0] alu_p1, rs2_p1, u_imm_p1, pc_p1;
  rv32i_control_word ctrl_p1;
  logic [4:0]        rd_p1;

  mem_state_t        state, state_nxt;
  logic              access, memop, request, misaligned;
  logic [3:0]        mbe;
  logic [DATA_W-1:0] wdata, ext_rdata;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .funct3     (ctrl_p1.funct3),
    .a          (alu_p1[1:0]),
    .rs2        (rs2_p1),
    .rdata      (dmem.rdata),
    .mbe        (mbe),
    .wdata      (wdata),
    .ext_rdata  (ext_rdata),
    .misaligned (misaligned)
  );

  assign access = vld_p1 & (ctrl_p1.mem_read | ctrl_p1.mem_write);
`ifdef MEM_MISALIGN_TRAP_EN
  assign memop = access & ~misaligned;
`else
  assign memop = access;
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

  // ---- EX/MEM boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      alu_p1   <= '0;
      rs2_p1   <= '0;
      ctrl_p1  <= '0;
      rd_p1    <= '0;
      u_imm_p1 <= '0;
      pc_p1    <= '0;
    end else if (!mem_stall) begin
      vld_p1   <= ex_valid;
      alu_p1   <= ex_alu_out;
      rs2_p1   <= ex_rs2_out;
      ctrl_p1  <= ex_ctrl;
      rd_p1    <= ex_rd;
      u_imm_p1 <= ex_u_imm;
      pc_p1    <= ex_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (memop & dmem.resp) state_nxt = RECOV;
               else if (memop)        state_nxt = WAIT;
      WAIT:    if (memop & dmem.resp) state_nxt = RECOV;
      RECOV:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RECOV drops the request for one cycle; a queued memop stalls through it
  always_comb begin
    request   = 1'b0;
    mem_stall = 1'b0;
    case (state)
      IDLE, WAIT: begin
        request   = memop;
        mem_stall = memop & ~dmem.resp;
      end
      RECOV:   mem_stall = memop;
      default: ;
    endcase
  end

  assign dmem.read  = request & ctrl_p1.mem_read;
  assign dmem.write = request & ctrl_p1.mem_write & ~ctrl_p1.mem_read;
  assign dmem.addr  = {alu_p1[ADDR_W-1:2], 2'b00};
  assign dmem.wdata = wdata;
  assign dmem.mbe   = dmem.write ? mbe : 4'b0000;

  // ---- MEM/WB boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid     <= 1'b0;
      wb_ctrl      <= '0;
      wb_rd        <= '0;
      wb_alu_out   <= '0;
      wb_mem_rdata <= '0;
      wb_u_imm     <= '0;
      wb_pc        <= '0;
    end else if (mem_stall) begin
      wb_valid     <= 1'b0;
    end else begin
      wb_valid     <= vld_p1;
      wb_ctrl      <= ctrl_p1;
      wb_rd        <= rd_p1;
      wb_alu_out   <= alu_p1;
      wb_mem_rdata <= (memop & ctrl_p1.mem_read) ? ext_rdata : '0;
      wb_u_imm     <= u_imm_p1;
      wb_pc        <= pc_p1;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            wb_misalign <= 1'b0;
    else if (mem_stall)  wb_misalign <= 1'b0;
    else                 wb_misalign <= access & misaligned;
  end
`else
  assign wb_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table of single accesses plus hand-written
// back-to-back, reset-mid-access and misalignment sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              ex_valid;
  logic [31:0]       ex_alu_out, ex_rs2_out, ex_u_imm, ex_pc;
  rv32i_control_word ex_ctrl;
  logic [4:0]        ex_rd;
  logic              mem_stall, wb_valid, wb_misalign;
  rv32i_control_word wb_ctrl;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_alu_out, wb_mem_rdata, wb_u_imm, wb_pc;

  mem_stage_if #(.ADDR_W(32), .DATA_W(32)) dmem ();

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_rs2_out(ex_rs2_out),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_u_imm(ex_u_imm), .ex_pc(ex_pc),
    .mem_stall(mem_stall), .dmem(dmem),
    .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .wb_alu_out(wb_alu_out),
    .wb_mem_rdata(wb_mem_rdata), .wb_u_imm(wb_u_imm), .wb_pc(wb_pc),
    .wb_misalign(wb_misalign)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic [31:0] ext;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rdn);
    ex_valid          = 1'b1;
    ex_alu_out        = addr;
    ex_rs2_out        = rs2;
    ex_ctrl.reg_write = ~wr;
    ex_ctrl.mem_read  = rd;
    ex_ctrl.mem_write = wr;
    ex_ctrl.funct3    = f3;
    ex_rd             = rdn;
    ex_u_imm          = {rdn, 27'h0ABCDEF};
    ex_pc             = 32'h0000_8000 + {25'b0, rdn, 2'b00};
  endtask

  // Called 1 ns after a rising edge; leaves the bench 1 ns after a later rising edge.
  task automatic run_vec(input vec_t v, input int i);
    logic [4:0] rdn;
    rdn = 5'(i + 1);
    issue(v.rd, v.wr, v.f3, v.addr, v.rs2, rdn);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (v.rd | v.wr) begin
      for (int c = 0; c < v.lat; c++) begin
        chk($sformatf("v%0d_addr", i),  dmem.addr, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_read", i),  32'(dmem.read),  32'(v.rd));
        chk($sformatf("v%0d_write", i), 32'(dmem.write), 32'(v.wr));
        chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        chk($sformatf("v%0d_bubble", i), 32'(wb_valid), 32'd0);
      end
      dmem.resp  = 1'b1;
      dmem.rdata = v.rdata;
      #1;
      chk($sformatf("v%0d_addr_r", i),  dmem.addr, v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_read_r", i),  32'(dmem.read),  32'(v.rd));
      chk($sformatf("v%0d_write_r", i), 32'(dmem.write), 32'(v.wr));
      chk($sformatf("v%0d_stall_r", i), 32'(mem_stall), 32'd0);
      if (v.wr) begin
        chk($sformatf("v%0d_mbe", i),   32'(dmem.mbe), 32'(v.mbe));
        chk($sformatf("v%0d_wdata", i), dmem.wdata, v.wdata);
      end
      @(posedge clk); #1;
      dmem.resp = 1'b0;
    end else begin
      // a stray response with no memop in MEM must be ignored
      dmem.resp  = 1'b1;
      dmem.rdata = v.rdata;
      #1;
      chk($sformatf("v%0d_noreq", i), 32'({dmem.read, dmem.write}), 32'd0);
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      dmem.resp = 1'b0;
      chk($sformatf("v%0d_state", i), 32'(dut.state), 32'(IDLE));
    end
    chk($sformatf("v%0d_wbv", i),   32'(wb_valid), 32'd1);
    chk($sformatf("v%0d_wbrd", i),  32'(wb_rd), 32'(rdn));
    chk($sformatf("v%0d_wbpc", i),  wb_pc, 32'h0000_8000 + {25'b0, rdn, 2'b00});
    chk($sformatf("v%0d_wbalu", i), wb_alu_out, v.addr);
    chk($sformatf("v%0d_wbimm", i), wb_u_imm, {rdn, 27'h0ABCDEF});
    chk($sformatf("v%0d_wbctl", i), 32'(wb_ctrl), 32'({~v.wr, v.rd, v.wr, v.f3}));
    chk($sformatf("v%0d_wbdat", i), wb_mem_rdata, v.ext);
    @(posedge clk); #1;
    chk($sformatf("v%0d_wbv_end", i), 32'(wb_valid), 32'd0);
  endtask

  initial begin
    //            rd   wr   f3      addr          rs2           rdata         lat mbe    wdata         ext
    vt[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 2, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h5A5A_5A5A, 1, 4'h8, 32'hAB00_0000, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h1111_1111, 32'h1234_8056, 0, 4'h0, 32'h0,         32'hFFFF_FF80};
    vt[3]  = '{1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h1111_1111, 32'h1234_8056, 1, 4'h0, 32'h0,         32'h0000_0080};
    vt[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h1111_1111, 32'hF00D_1234, 0, 4'h0, 32'h0,         32'h0000_F00D};
    vt[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h1111_1111, 32'h8001_0000, 2, 4'h0, 32'h0,         32'hFFFF_8001};
    vt[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h0000_BEEF, 32'h5A5A_5A5A, 0, 4'hC, 32'hBEEF_0000, 32'h0};
    vt[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_1001, 32'h0000_0012, 32'h5A5A_5A5A, 1, 4'h2, 32'h0000_1200, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'h1111_1111, 32'hCAFE_F00D, 1, 4'h0, 32'h0,         32'hCAFE_F00D};
    vt[9]  = '{1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h1111_1111, 32'hFFFF_FFFF, 0, 4'h0, 32'h0,         32'h0};
    vt[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'h1111_1111, 32'h1234_7FFE, 0, 4'h0, 32'h0,         32'h0000_7FFE};

    ex_valid = 1'b0; ex_alu_out = '0; ex_rs2_out = '0; ex_ctrl = '0;
    ex_rd = '0; ex_u_imm = '0; ex_pc = '0;
    dmem.resp = 1'b0; dmem.rdata = '0;

    // reset state
    #2;
    chk("rst_wbv",   32'(wb_valid), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_req",   32'({dmem.read, dmem.write}), 32'd0);
    chk("rst_mbe",   32'(dmem.mbe), 32'd0);
    chk("rst_addr",  dmem.addr, 32'd0);
    chk("rst_wdata", dmem.wdata, 32'd0);
    chk("rst_wbdat", wb_mem_rdata, 32'd0);
    chk("rst_mis",   32'(wb_misalign), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    #10 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(vt[i], i);

    // back-to-back lw then sw, response one cycle after each request
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd20);
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_4004, 32'h0BAD_F00D, 5'd21);
    chk("b2b_lw_req",   32'(dmem.read), 32'd1);
    chk("b2b_lw_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    chk("b2b_hold_wbv", 32'(wb_valid), 32'd0);
    dmem.resp = 1'b1; dmem.rdata = 32'h7654_3210;
    #1;
    chk("b2b_lw_done_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    dmem.resp = 1'b0; ex_valid = 1'b0;
    chk("b2b_lw_wbv",   32'(wb_valid), 32'd1);
    chk("b2b_lw_wbrd",  32'(wb_rd), 32'd20);
    chk("b2b_lw_wbdat", wb_mem_rdata, 32'h7654_3210);
    chk("b2b_recov_req",   32'({dmem.read, dmem.write}), 32'd0);
    chk("b2b_recov_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    chk("b2b_recov_wbv", 32'(wb_valid), 32'd0);
    chk("b2b_sw_req",    32'({dmem.read, dmem.write}), 32'd1);
    chk("b2b_sw_addr",   dmem.addr, 32'h0000_4004);
    chk("b2b_sw_wdata",  dmem.wdata, 32'h0BAD_F00D);
    @(posedge clk); #1;
    dmem.resp = 1'b1;
    #1;
    chk("b2b_sw_done_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    dmem.resp = 1'b0;
    chk("b2b_sw_wbv",  32'(wb_valid), 32'd1);
    chk("b2b_sw_wbrd", 32'(wb_rd), 32'd21);
    @(posedge clk); #1;

    // asynchronous reset while waiting on the cache
    issue(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd22);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rw_req", 32'(dmem.read), 32'd1);
    @(posedge clk); #1;
    chk("rw_wait_state", 32'(dut.state), 32'(WAIT));
    rst = 1'b0;
    #1;
    chk("rw_req_drop", 32'(dmem.read), 32'd0);
    chk("rw_stall",    32'(mem_stall), 32'd0);
    chk("rw_wbv",      32'(wb_valid), 32'd0);
    chk("rw_state",    32'(dut.state), 32'(IDLE));
    dmem.resp = 1'b1; dmem.rdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rw_late_resp_req", 32'({dmem.read, dmem.write}), 32'd0);
    @(posedge clk); #1;
    dmem.resp = 1'b0;
    chk("rw_late_resp_wbv",   32'(wb_valid), 32'd0);
    chk("rw_late_resp_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd23);
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 3'b001, 32'h0000_1003, 32'h0000_BEEF, 5'd24);
    chk("mis_lw_req",   32'({dmem.read, dmem.write}), 32'd0);
    chk("mis_lw_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("mis_lw_wbv",   32'(wb_valid), 32'd1);
    chk("mis_lw_flag",  32'(wb_misalign), 32'd1);
    chk("mis_lw_wbdat", wb_mem_rdata, 32'd0);
    chk("mis_sh_req",   32'({dmem.read, dmem.write}), 32'd0);
    @(posedge clk); #1;
    chk("mis_sh_wbrd",  32'(wb_rd), 32'd24);
    chk("mis_sh_flag",  32'(wb_misalign), 32'd1);
    @(posedge clk); #1;
    chk("mis_idle_flag", 32'(wb_misalign), 32'd0);
`else
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd23);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("nomis_lw_req",  32'(dmem.read), 32'd1);
    chk("nomis_lw_addr", dmem.addr, 32'h0000_3000);
    dmem.resp = 1'b1; dmem.rdata = 32'h8765_4321;
    #1;
    chk("nomis_lw_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    dmem.resp = 1'b0;
    chk("nomis_lw_wbdat", wb_mem_rdata, 32'h8765_4321);
    chk("nomis_lw_flag",  32'(wb_misalign), 32'd0);
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 3'b001, 32'h0000_1003, 32'h0000_BEEF, 5'd24);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    dmem.resp = 1'b1;
    #1;
    chk("nomis_sh_mbe",   32'(dmem.mbe), 32'h8);
    chk("nomis_sh_wdata", dmem.wdata, 32'hEF00_0000);
    @(posedge clk); #1;
    dmem.resp = 1'b0;
    chk("nomis_sh_wbv", 32'(wb_valid), 32'd1);
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
